// File: rtl/wb_stage.sv
// wb_stage - write-back stage: regfile write port, HI/LO registers, one-entry bypass, retire counter.
module wb_stage #(
  parameter int PC_BITS   = 32,
  parameter int IR_BITS   = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en,
  input  logic [PC_BITS-1:0]   pc_in,
  input  logic [IR_BITS-1:0]   ir_in,
  input  logic                 jal,
  input  logic                 mem_to_reg,
  input  logic                 reg_write,
  input  logic                 write_rd,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  input  logic                 to_lh,
  input  logic [1:0]           lh_to_reg,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] mem_out,
  input  logic [DATA_BITS-1:0] lo_in,
  input  logic [DATA_BITS-1:0] hi_in,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_BITS-1:0] rf_wdata,
  output logic [DATA_BITS-1:0] hi_q,
  output logic [DATA_BITS-1:0] lo_q,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_addr,
  output logic [DATA_BITS-1:0] fwd_data,
  output logic [31:0]          retired_cnt
);

  logic                 live;
  logic [1:0]           off;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [DATA_BITS-1:0] load_data;
  logic [DATA_BITS-1:0] link_data;

  assign live      = wb_en & (ir_in != '0);
  assign off       = alu_out[1:0];
  assign link_data = DATA_BITS'(pc_in + PC_BITS'(4));

  always_comb begin
    rf_waddr = 5'd31;
    if (!jal) begin
      rf_waddr = write_rd ? ir_in[15:11] : ir_in[20:16];
    end
  end

  always_comb begin
    byte_sel = mem_out[8*off +: 8];
    half_sel = off[1] ? mem_out[31:16] : mem_out[15:0];
    case (extr_word)
      2'b01:   load_data = {{(DATA_BITS-8){byte_sel[7] & extr_signed}}, byte_sel};
      2'b10:   load_data = {{(DATA_BITS-16){half_sel[15] & extr_signed}}, half_sel};
      default: load_data = mem_out;
    endcase
  end

  // HI/LO reads see the pre-update registers, so a combined to_lh + move returns the old value.
  always_comb begin
    rf_wdata = alu_out;
    if (jal)                     rf_wdata = link_data;
    else if (lh_to_reg == 2'b01) rf_wdata = lo_q;
    else if (lh_to_reg == 2'b10) rf_wdata = hi_q;
    else if (mem_to_reg)         rf_wdata = load_data;
  end

  assign rf_we = live & (reg_write | jal) & (rf_waddr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      fwd_valid   <= 1'b0;
      fwd_addr    <= 5'd0;
      fwd_data    <= '0;
      retired_cnt <= 32'd0;
    end else if (live) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (to_lh) begin
        hi_q <= hi_in;
        lo_q <= lo_in;
      end
      if (rf_we) begin
        fwd_valid <= 1'b1;
        fwd_addr  <= rf_waddr;
        fwd_data  <= rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage - directed vectors for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [31:0] pc_in;
  logic [31:0] ir_in;
  logic        jal;
  logic        mem_to_reg;
  logic        reg_write;
  logic        write_rd;
  logic [1:0]  extr_word;
  logic        extr_signed;
  logic        to_lh;
  logic [1:0]  lh_to_reg;
  logic [31:0] alu_out;
  logic [31:0] mem_out;
  logic [31:0] lo_in;
  logic [31:0] hi_in;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .pc_in(pc_in), .ir_in(ir_in),
    .jal(jal), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .write_rd(write_rd),
    .extr_word(extr_word), .extr_signed(extr_signed), .to_lh(to_lh), .lh_to_reg(lh_to_reg),
    .alu_out(alu_out), .mem_out(mem_out), .lo_in(lo_in), .hi_in(hi_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .retired_cnt(retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_slot();
    wb_en = 1'b1; pc_in = '0; ir_in = '0; jal = 1'b0; mem_to_reg = 1'b0;
    reg_write = 1'b0; write_rd = 1'b0; extr_word = 2'b00; extr_signed = 1'b0;
    to_lh = 1'b0; lh_to_reg = 2'b00; alu_out = '0; mem_out = '0; lo_in = '0; hi_in = '0;
  endtask

  // Commit the current slot on the next rising edge, then return to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clear_slot();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'h0);
    check("rst_fwd_addr", {27'd0, fwd_addr}, 32'h0);
    check("rst_fwd_data", fwd_data, 32'h0);
    check("rst_retired", retired_cnt, 32'h0);

    // lb / lbu at byte offset 2, dest rt=5
    @(negedge clk);
    clear_slot();
    ir_in = 32'h8C05_0000; reg_write = 1'b1; mem_to_reg = 1'b1;
    extr_word = 2'b01; extr_signed = 1'b1; alu_out = 32'h0000_1002; mem_out = 32'h8899_AABB;
    #1;
    check("lb_we", {31'd0, rf_we}, 32'h1);
    check("lb_addr", {27'd0, rf_waddr}, 32'd5);
    check("lb_data", rf_wdata, 32'hFFFF_FF99);
    extr_signed = 1'b0;
    #1;
    check("lbu_data", rf_wdata, 32'h0000_0099);
    step();
    check("lbu_fwd_valid", {31'd0, fwd_valid}, 32'h1);
    check("lbu_fwd_addr", {27'd0, fwd_addr}, 32'd5);
    check("lbu_fwd_data", fwd_data, 32'h0000_0099);
    check("lbu_retired", retired_cnt, 32'd1);

    // lh at offset 0, then lhu at offset 2
    clear_slot();
    ir_in = 32'h8C06_0000; reg_write = 1'b1; mem_to_reg = 1'b1;
    extr_word = 2'b10; extr_signed = 1'b1; alu_out = 32'h0000_2000; mem_out = 32'h1234_8000;
    #1;
    check("lh_data", rf_wdata, 32'hFFFF_8000);
    alu_out = 32'h0000_2002; extr_signed = 1'b0;
    #1;
    check("lhu_data", rf_wdata, 32'h0000_1234);
    step();
    check("lhu_fwd_data", fwd_data, 32'h0000_1234);
    check("lhu_retired", retired_cnt, 32'd2);

    // jal: link into $31, overriding mem_to_reg
    clear_slot();
    ir_in = 32'h0C00_0004; jal = 1'b1; pc_in = 32'h0040_0010; mem_to_reg = 1'b1; mem_out = 32'hDEAD_BEEF;
    #1;
    check("jal_we", {31'd0, rf_we}, 32'h1);
    check("jal_addr", {27'd0, rf_waddr}, 32'd31);
    check("jal_data", rf_wdata, 32'h0040_0014);
    step();
    check("jal_fwd_valid", {31'd0, fwd_valid}, 32'h1);
    check("jal_fwd_addr", {27'd0, fwd_addr}, 32'd31);
    check("jal_fwd_data", fwd_data, 32'h0040_0014);

    // mult-style write of HI/LO, no regfile write
    clear_slot();
    ir_in = 32'h0085_0018; to_lh = 1'b1; hi_in = 32'hA; lo_in = 32'hB;
    #1;
    check("mult_we", {31'd0, rf_we}, 32'h0);
    step();
    check("mult_hi", hi_q, 32'hA);
    check("mult_lo", lo_q, 32'hB);
    check("mult_fwd_addr", {27'd0, fwd_addr}, 32'd31);
    check("mult_retired", retired_cnt, 32'd4);

    // mfhi into rd=8
    clear_slot();
    ir_in = 32'h0000_4010; reg_write = 1'b1; write_rd = 1'b1; lh_to_reg = 2'b10; alu_out = 32'h5555_5555;
    #1;
    check("mfhi_addr", {27'd0, rf_waddr}, 32'd8);
    check("mfhi_data", rf_wdata, 32'hA);
    step();

    // mflo that also loads HI/LO returns the old LO
    clear_slot();
    ir_in = 32'h0000_4812; reg_write = 1'b1; write_rd = 1'b1; lh_to_reg = 2'b01;
    to_lh = 1'b1; hi_in = 32'h77; lo_in = 32'h66;
    #1;
    check("mflo_addr", {27'd0, rf_waddr}, 32'd9);
    check("mflo_old_data", rf_wdata, 32'hB);
    step();
    check("mflo_hi", hi_q, 32'h77);
    check("mflo_lo", lo_q, 32'h66);
    check("mflo_fwd_addr", {27'd0, fwd_addr}, 32'd9);
    check("mflo_fwd_data", fwd_data, 32'hB);
    check("mflo_retired", retired_cnt, 32'd6);

    // write to $0: suppressed, bypass holds, still retires
    clear_slot();
    ir_in = 32'h2400_0055; reg_write = 1'b1; alu_out = 32'h1234_5678;
    #1;
    check("r0_we", {31'd0, rf_we}, 32'h0);
    check("r0_data_alu", rf_wdata, 32'h1234_5678);
    step();
    check("r0_fwd_addr", {27'd0, fwd_addr}, 32'd9);
    check("r0_fwd_data", fwd_data, 32'hB);
    check("r0_retired", retired_cnt, 32'd7);

    // wb_en=0: nothing happens
    clear_slot();
    wb_en = 1'b0; ir_in = 32'h2403_0001; reg_write = 1'b1; to_lh = 1'b1; hi_in = 32'h1; lo_in = 32'h2;
    #1;
    check("hold_we", {31'd0, rf_we}, 32'h0);
    step();
    check("hold_retired", retired_cnt, 32'd7);
    check("hold_hi", hi_q, 32'h77);
    check("hold_fwd_addr", {27'd0, fwd_addr}, 32'd9);

    // bubble: nothing happens
    clear_slot();
    ir_in = 32'h0; reg_write = 1'b1; jal = 1'b1; to_lh = 1'b1; lo_in = 32'h3;
    #1;
    check("bubble_we", {31'd0, rf_we}, 32'h0);
    step();
    check("bubble_retired", retired_cnt, 32'd7);
    check("bubble_lo", lo_q, 32'h66);
    check("bubble_fwd_data", fwd_data, 32'hB);

    // counter wrap from all-ones
    clear_slot();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    #1;
    check("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
    ir_in = 32'h2400_0000;
    step();
    check("wrap_retired", retired_cnt, 32'h0);

    // asynchronous reset between edges
    clear_slot();
    ir_in = 32'h0000_0018; to_lh = 1'b1; hi_in = 32'hC; lo_in = 32'hD;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_hi", hi_q, 32'h0);
    check("arst_lo", lo_q, 32'h0);
    check("arst_fwd_valid", {31'd0, fwd_valid}, 32'h0);
    check("arst_fwd_addr", {27'd0, fwd_addr}, 32'h0);
    check("arst_fwd_data", fwd_data, 32'h0);
    check("arst_retired", retired_cnt, 32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
